// File: rtl/reg_file_sb.sv
// Two-write/two-read register file with per-register busy scoreboard; reads are zero-latency, writes/issues commit on clk, no backpressure.
// Define RF_BYPASS_EN to forward same-cycle write data (and busy clear) to the read ports.
module reg_file_sb #(
   parameter int REG_WIDTH = 32,
   parameter int REG_COUNT = 32,
   parameter int IDX_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en_0,
   input  logic [IDX_WIDTH-1:0] wr_idx_0,
   input  logic [REG_WIDTH-1:0] wr_data_0,
   input  logic                 wr_en_1,
   input  logic [IDX_WIDTH-1:0] wr_idx_1,
   input  logic [REG_WIDTH-1:0] wr_data_1,
   input  logic [IDX_WIDTH-1:0] rd_idx_1,
   output logic [REG_WIDTH-1:0] rd_data_1,
   output logic                 rd_busy_1,
   input  logic [IDX_WIDTH-1:0] rd_idx_2,
   output logic [REG_WIDTH-1:0] rd_data_2,
   output logic                 rd_busy_2,
   input  logic                 issue_en,
   input  logic [IDX_WIDTH-1:0] issue_idx,
   output logic [IDX_WIDTH:0]   busy_count
);

   // Storage spans the full index space so any index selects safely; slots at
   // or above REG_COUNT are never written and stay at their reset value.
   localparam int DEPTH = 1 << IDX_WIDTH;
   localparam logic [IDX_WIDTH:0] COUNT_LIM = (IDX_WIDTH+1)'(REG_COUNT);

   logic [REG_WIDTH-1:0] regs_q [DEPTH];
   logic [REG_WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]     busy_q, busy_d;
   logic [IDX_WIDTH:0]   busy_count_q, busy_count_d;
   logic [IDX_WIDTH:0]   set_cnt, clr_cnt;
   logic                 wr_ok_0, wr_ok_1, iss_ok;

   function automatic logic idx_ok(input logic [IDX_WIDTH-1:0] idx);
      return (idx != '0) && ({1'b0, idx} < COUNT_LIM);
   endfunction

   assign wr_ok_0 = wr_en_0 && idx_ok(wr_idx_0);
   assign wr_ok_1 = wr_en_1 && idx_ok(wr_idx_1);
   assign iss_ok  = issue_en && idx_ok(issue_idx);

   // Port 1 is applied after port 0 so it wins a same-index collision; the
   // issue is applied last so a new producer keeps the register busy.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_ok_0) begin
         regs_d[wr_idx_0] = wr_data_0;
         busy_d[wr_idx_0] = 1'b0;
      end
      if (wr_ok_1) begin
         regs_d[wr_idx_1] = wr_data_1;
         busy_d[wr_idx_1] = 1'b0;
      end
      if (iss_ok) begin
         busy_d[issue_idx] = 1'b1;
      end
      set_cnt = '0;
      clr_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (busy_d[i] && !busy_q[i]) set_cnt = set_cnt + 1'b1;
         if (!busy_d[i] && busy_q[i]) clr_cnt = clr_cnt + 1'b1;
      end
      busy_count_d = busy_count_q + set_cnt - clr_cnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

`ifdef RF_BYPASS_EN
   function automatic logic fwd_hit(input logic [IDX_WIDTH-1:0] idx);
      return (wr_ok_0 && wr_idx_0 == idx) || (wr_ok_1 && wr_idx_1 == idx);
   endfunction

   function automatic logic [REG_WIDTH-1:0] fwd_data(input logic [IDX_WIDTH-1:0] idx);
      return (wr_ok_1 && wr_idx_1 == idx) ? wr_data_1 : wr_data_0;
   endfunction

   function automatic logic fwd_busy(input logic [IDX_WIDTH-1:0] idx);
      return iss_ok && issue_idx == idx;
   endfunction
`endif

   always_comb begin
      rd_data_1 = '0;
      rd_busy_1 = 1'b0;
      rd_data_2 = '0;
      rd_busy_2 = 1'b0;
      if (rst && idx_ok(rd_idx_1)) begin
         rd_data_1 = regs_q[rd_idx_1];
         rd_busy_1 = busy_q[rd_idx_1];
`ifdef RF_BYPASS_EN
         if (fwd_hit(rd_idx_1)) begin
            rd_data_1 = fwd_data(rd_idx_1);
            rd_busy_1 = fwd_busy(rd_idx_1);
         end
`endif
      end
      if (rst && idx_ok(rd_idx_2)) begin
         rd_data_2 = regs_q[rd_idx_2];
         rd_busy_2 = busy_q[rd_idx_2];
`ifdef RF_BYPASS_EN
         if (fwd_hit(rd_idx_2)) begin
            rd_data_2 = fwd_data(rd_idx_2);
            rd_busy_2 = fwd_busy(rd_idx_2);
         end
`endif
      end
   end

   assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (REG_COUNT=16) using an expected-value queue.
module tb_reg_file_sb;
   localparam int W  = 32;
   localparam int RC = 16;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en_0, wr_en_1, issue_en;
   logic [IW-1:0] wr_idx_0, wr_idx_1, rd_idx_1, rd_idx_2, issue_idx;
   logic [W-1:0]  wr_data_0, wr_data_1, rd_data_1, rd_data_2;
   logic          rd_busy_1, rd_busy_2;
   logic [IW:0]   busy_count;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;

`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   reg_file_sb #(.REG_WIDTH(W), .REG_COUNT(RC), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .wr_en_0(wr_en_0), .wr_idx_0(wr_idx_0), .wr_data_0(wr_data_0),
      .wr_en_1(wr_en_1), .wr_idx_1(wr_idx_1), .wr_data_1(wr_data_1),
      .rd_idx_1(rd_idx_1), .rd_data_1(rd_data_1), .rd_busy_1(rd_busy_1),
      .rd_idx_2(rd_idx_2), .rd_data_2(rd_data_2), .rd_busy_2(rd_busy_2),
      .issue_en(issue_en), .issue_idx(issue_idx), .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      wr_en_0 = 1'b0; wr_idx_0 = '0; wr_data_0 = '0;
      wr_en_1 = 1'b0; wr_idx_1 = '0; wr_data_1 = '0;
      issue_en = 1'b0; issue_idx = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      rd_idx_1 = '0; rd_idx_2 = '0;
      #1 rst = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
         rd_idx_1 = IW'(i);
         rd_idx_2 = IW'(31 - i);
         exp_q.push_back('0);
         exp_q.push_back('0);
         #1;
         e = exp_q.pop_front(); n_checks++;
         if (rd_data_1 !== e) begin n_fail++; $display("FAIL reset_rd_data_1 idx=%0d got=%h exp=%h", i, rd_data_1, e); end
         e = exp_q.pop_front(); n_checks++;
         if (rd_data_2 !== e) begin n_fail++; $display("FAIL reset_rd_data_2 idx=%0d got=%h exp=%h", 31 - i, rd_data_2, e); end
         n_checks++;
         if ({rd_busy_1, rd_busy_2} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy idx=%0d got=%b exp=00", i, {rd_busy_1, rd_busy_2}); end
      end
      n_checks++;
      if (busy_count !== '0) begin n_fail++; $display("FAIL reset_busy_count got=%0d exp=0", busy_count); end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_write();
      wr_en_0 = 1'b1; wr_idx_0 = 5'd5; wr_data_0 = 32'hDEADBEEF; rd_idx_1 = 5'd5;
      exp_q.push_back(BYP ? 32'hDEADBEEF : 32'h0);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_1 !== e) begin n_fail++; $display("FAIL write_same_cycle got=%h exp=%h", rd_data_1, e); end
      step();
      idle();
      exp_q.push_back(32'hDEADBEEF);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_1 !== e) begin n_fail++; $display("FAIL write_r5 got=%h exp=%h", rd_data_1, e); end
      wr_en_0 = 1'b1; wr_idx_0 = 5'd0; wr_data_0 = 32'h1; rd_idx_1 = 5'd0;
      wr_en_1 = 1'b1; wr_idx_1 = 5'd16; wr_data_1 = 32'h1234; rd_idx_2 = 5'd16;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      step();
      idle();
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_1 !== e) begin n_fail++; $display("FAIL write_r0 got=%h exp=%h", rd_data_1, e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_2 !== e) begin n_fail++; $display("FAIL write_out_of_range got=%h exp=%h", rd_data_2, e); end
   endtask

   task automatic test_same_idx();
      wr_en_0 = 1'b1; wr_idx_0 = 5'd7; wr_data_0 = 32'hAAAA;
      wr_en_1 = 1'b1; wr_idx_1 = 5'd7; wr_data_1 = 32'h5555;
      rd_idx_1 = 5'd7; rd_idx_2 = 5'd5;
      exp_q.push_back(BYP ? 32'h5555 : 32'h0);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_1 !== e) begin n_fail++; $display("FAIL collide_same_cycle got=%h exp=%h", rd_data_1, e); end
      step();
      idle();
      exp_q.push_back(32'h5555);
      exp_q.push_back(32'hDEADBEEF);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_1 !== e) begin n_fail++; $display("FAIL collide_port1_wins got=%h exp=%h", rd_data_1, e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_2 !== e) begin n_fail++; $display("FAIL collide_r5_kept got=%h exp=%h", rd_data_2, e); end
   endtask

   task automatic test_scoreboard();
      logic [IW-1:0] iss_seq [3];
      logic [W-1:0]  cnt_seq [3];
      iss_seq[0] = 5'd3; iss_seq[1] = 5'd4; iss_seq[2] = 5'd3;
      cnt_seq[0] = 1;    cnt_seq[1] = 2;    cnt_seq[2] = 2;
      rd_idx_1 = 5'd3; rd_idx_2 = 5'd4;
      for (int i = 0; i < 3; i++) begin
         issue_en = 1'b1; issue_idx = iss_seq[i];
         exp_q.push_back(cnt_seq[i]);
         step();
         idle();
         e = exp_q.pop_front(); n_checks++;
         if (32'(busy_count) !== e) begin n_fail++; $display("FAIL issue_count step=%0d got=%0d exp=%0d", i, busy_count, e); end
      end
      n_checks++;
      if ({rd_busy_1, rd_busy_2} !== 2'b11) begin n_fail++; $display("FAIL issue_busy got=%b exp=11", {rd_busy_1, rd_busy_2}); end
      wr_en_0 = 1'b1; wr_idx_0 = 5'd3; wr_data_0 = 32'h33;
      exp_q.push_back(BYP ? 32'h0 : 32'h1);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (32'(rd_busy_1) !== e) begin n_fail++; $display("FAIL write_busy_same_cycle got=%b exp=%0d", rd_busy_1, e); end
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'h33);
      step();
      idle();
      e = exp_q.pop_front(); n_checks++;
      if (32'(busy_count) !== e) begin n_fail++; $display("FAIL write_clear_count got=%0d exp=%0d", busy_count, e); end
      e = exp_q.pop_front(); n_checks++;
      if (32'(rd_busy_1) !== e) begin n_fail++; $display("FAIL write_clear_busy got=%b exp=%0d", rd_busy_1, e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_1 !== e) begin n_fail++; $display("FAIL write_r3_data got=%h exp=%h", rd_data_1, e); end
      issue_en = 1'b1; issue_idx = 5'd4;
      wr_en_1 = 1'b1; wr_idx_1 = 5'd4; wr_data_1 = 32'h44;
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (32'(rd_busy_2) !== e) begin n_fail++; $display("FAIL issue_write_busy_same_cycle got=%b exp=%0d", rd_busy_2, e); end
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'h44);
      step();
      idle();
      e = exp_q.pop_front(); n_checks++;
      if (32'(busy_count) !== e) begin n_fail++; $display("FAIL issue_write_count got=%0d exp=%0d", busy_count, e); end
      e = exp_q.pop_front(); n_checks++;
      if (32'(rd_busy_2) !== e) begin n_fail++; $display("FAIL issue_write_busy got=%b exp=%0d", rd_busy_2, e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_2 !== e) begin n_fail++; $display("FAIL issue_write_data got=%h exp=%h", rd_data_2, e); end
      wr_en_0 = 1'b1; wr_idx_0 = 5'd12; wr_data_0 = 32'hC;
      exp_q.push_back(32'd1);
      step();
      idle();
      e = exp_q.pop_front(); n_checks++;
      if (32'(busy_count) !== e) begin n_fail++; $display("FAIL write_idle_count got=%0d exp=%0d", busy_count, e); end
   endtask

   task automatic test_reset_mid();
      rd_idx_1 = 5'd10; rd_idx_2 = 5'd9;
      issue_en = 1'b1; issue_idx = 5'd9;
      wr_en_0 = 1'b1; wr_idx_0 = 5'd10; wr_data_0 = 32'hA0;
      wr_en_1 = 1'b1; wr_idx_1 = 5'd11; wr_data_1 = 32'hB0;
      exp_q.push_back(32'hA0);
      exp_q.push_back(32'd2);
      step();
      e = exp_q.pop_front(); n_checks++;
      if (rd_data_1 !== e) begin n_fail++; $display("FAIL mid_pre_data got=%h exp=%h", rd_data_1, e); end
      e = exp_q.pop_front(); n_checks++;
      if (32'(busy_count) !== e) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=%0d", busy_count, e); end
      wr_data_0 = 32'hFF; wr_data_1 = 32'hEE; issue_idx = 5'd11;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({rd_data_1, rd_busy_2, busy_count} !== '0) begin n_fail++; $display("FAIL mid_in_reset got data=%h busy=%b count=%0d exp=0", rd_data_1, rd_busy_2, busy_count); end
      @(posedge clk);
      #1;
      idle();
      rst = 1'b1;
      for (int i = 9; i <= 11; i++) begin
         rd_idx_1 = IW'(i); rd_idx_2 = IW'(i);
         exp_q.push_back(32'h0);
         #1;
         e = exp_q.pop_front(); n_checks++;
         if (rd_data_1 !== e || rd_busy_2 !== 1'b0) begin n_fail++; $display("FAIL mid_post_reg idx=%0d got data=%h busy=%b exp=%h/0", i, rd_data_1, rd_busy_2, e); end
      end
      exp_q.push_back(32'd0);
      step();
      e = exp_q.pop_front(); n_checks++;
      if (32'(busy_count) !== e) begin n_fail++; $display("FAIL mid_post_count got=%0d exp=%0d", busy_count, e); end
   endtask

   task automatic test_out_of_range();
      logic [IW-1:0] bad [3];
      bad[0] = 5'd0; bad[1] = 5'd16; bad[2] = 5'd31;
      for (int i = 0; i < 3; i++) begin
         issue_en = 1'b1; issue_idx = bad[i];
         rd_idx_1 = bad[i]; rd_idx_2 = bad[i];
         exp_q.push_back(32'd0);
         step();
         idle();
         e = exp_q.pop_front(); n_checks++;
         if (32'(busy_count) !== e || {rd_busy_1, rd_busy_2} !== 2'b00) begin
            n_fail++;
            $display("FAIL oob_issue idx=%0d got count=%0d busy=%b exp=%0d/00", bad[i], busy_count, {rd_busy_1, rd_busy_2}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_same_idx();
      test_scoreboard();
      test_reset_mid();
      test_out_of_range();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
